// File: rtl/ram_pkg.sv
// Shared default geometry for the simple dual-port RAM.
package ram_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

endpackage : ram_pkg

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-old on collision.
// q is cleared asynchronously by a flag register kept outside the array so the array stays block-RAM inferable.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Timing contract: rden/rdaddress sampled on a rising edge -> q valid after that edge, held until the next read.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_valid_d;

    // Writes ignore reset so a write in flight is always applied whole.
    always_ff @(posedge clock) begin
        if (wren == 1'b1) begin
            mem[wraddress] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (rden == 1'b1) begin
            rd_data_q <= mem[rdaddress];
        end
    end

    // rd_data_q may load during reset; rd_valid_q masks it until the first read after release.
    assign rd_valid_d = rd_valid_q | (rden == 1'b1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign q = rd_valid_q ? rd_data_q : '0;

    a_wren_known : assert property (@(posedge clock) !$isunknown(wren))
        else $warning("ram: wren is X/Z, treated as 0");
    a_rden_known : assert property (@(posedge clock) !$isunknown(rden))
        else $warning("ram: rden is X/Z, treated as 0");

endmodule : ram

// File: tb/tb_ram.sv
// Directed bench for ram: driver pushes expected read data, a monitor pops and compares after each read edge.
module tb_ram;

    localparam int DW = 8;
    localparam int AW = 14;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] data;
    logic [AW-1:0] wraddress;
    logic          wren;
    logic [AW-1:0] rdaddress;
    logic          rden;
    logic [DW-1:0] q;

    logic [DW-1:0] exp_q[$];
    int            n_total;
    int            n_pass;
    logic          mon_fire;
    logic [DW-1:0] mon_exp;
    logic [AW-1:0] mon_addr;
    logic [AW-1:0] ra_q[$];

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, applied at the falling edge; a read pushes its expected data.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
        @(negedge clock);
        wren      = we;
        wraddress = wa;
        data      = wd;
        rden      = re;
        rdaddress = ra;
        if (re && reset_n) begin
            exp_q.push_back(exp);
            ra_q.push_back(ra);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0);
        end
    endtask

    // monitor
    always begin
        @(posedge clock);
        mon_fire = (rden === 1'b1) && (reset_n === 1'b1);
        #1;
        if (mon_fire) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got 0x%02h expected no read", q);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_addr = ra_q.pop_front();
                check($sformatf("read@%0d", mon_addr), q, mon_exp);
            end
        end
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        wren      = 1'b0;
        rden      = 1'b0;
        data      = '0;
        wraddress = '0;
        rdaddress = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_q", q, 8'h00);
        reset_n = 1'b1;

        // never-written locations read zero, including the top address
        drive(1'b0, '0, '0, 1'b1, 14'd0, 8'h00);
        drive(1'b0, '0, '0, 1'b1, 14'd1, 8'h00);
        drive(1'b0, '0, '0, 1'b1, 14'd16383, 8'h00);

        // write then read next cycle
        drive(1'b1, 14'd5, 8'hA5, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 14'd5, 8'hA5);

        // read-during-write to the same address returns old data
        drive(1'b1, 14'd7, 8'h11, 1'b0, '0, '0);
        drive(1'b1, 14'd7, 8'h3C, 1'b1, 14'd7, 8'h11);
        drive(1'b0, '0, '0, 1'b1, 14'd7, 8'h3C);

        // different addresses in the same edge are independent
        drive(1'b1, 14'd8, 8'h77, 1'b1, 14'd5, 8'hA5);
        drive(1'b0, '0, '0, 1'b1, 14'd8, 8'h77);

        // hold with rden low while rdaddress moves
        drive(1'b0, '0, '0, 1'b1, 14'd5, 8'hA5);
        drive(1'b0, '0, '0, 1'b0, 14'd9, '0);
        drive(1'b0, '0, '0, 1'b0, 14'd7, '0);
        @(negedge clock);
        check("hold_q", q, 8'hA5);

        // mid-cycle reset pulse: q clears at once, writes still land, reads suppressed
        #2 reset_n = 1'b0;
        #1 check("async_clear", q, 8'h00);
        wren      = 1'b1;
        wraddress = 14'd9;
        data      = 8'h5A;
        rden      = 1'b1;
        rdaddress = 14'd5;
        @(negedge clock);
        check("read_in_reset", q, 8'h00);
        wren    = 1'b0;
        rden    = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("after_release", q, 8'h00);
        drive(1'b0, '0, '0, 1'b1, 14'd5, 8'hA5);
        drive(1'b0, '0, '0, 1'b1, 14'd9, 8'h5A);

        // full sweep: write addr mod 256, then stream reads
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, AW'(a), DW'(a % 256), 1'b0, '0, '0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(a), DW'(a % 256));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ram
